// File: rtl/hazard_unit.sv
// Pipeline hazard unit: forwarding, load-use/branch stalls, and a wait-state FSM with timeout for the data memory.
// Optional performance counters are enabled by defining HAZARD_PERF_EN.
module hazard_unit #(
   parameter int MEM_TIMEOUT = 16,
   parameter int CNT_W       = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [4:0]       rsD,
   input  logic [4:0]       rtD,
   input  logic [4:0]       rsE,
   input  logic [4:0]       rtE,
   input  logic [4:0]       writeregE,
   input  logic [4:0]       writeregM,
   input  logic [4:0]       writeregW,
   input  logic             regwriteE,
   input  logic             regwriteM,
   input  logic             regwriteW,
   input  logic             memtoregE,
   input  logic             memtoregM,
   input  logic             branchD,
   input  logic             memreqM,
   input  logic             memreadyM,
   output logic             stallF,
   output logic             stallD,
   output logic             stallE,
   output logic             stallM,
   output logic             flushE,
   output logic             flushW,
   output logic             forwardAD,
   output logic             forwardBD,
   output logic [1:0]       forwardAE,
   output logic [1:0]       forwardBE,
   output logic             memerr,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   typedef enum logic [1:0] {RUN, WAIT, ERR} state_t;

   localparam logic [7:0] WCNT_LAST = 8'(MEM_TIMEOUT - 1);

   state_t     state_q, state_d;
   logic [7:0] wcnt_q, wcnt_d;
   logic       memstall;
   logic       lwstall;
   logic       branchstall;

   // M-stage result takes priority over W-stage result; $0 never forwards.
   function automatic logic [1:0] fwd_sel(input logic [4:0] rs,
                                          input logic [4:0] wr_m, input logic rw_m,
                                          input logic [4:0] wr_w, input logic rw_w);
      logic [1:0] sel;
      sel = 2'b00;
      if (rs != 5'd0 && rs == wr_m && rw_m)      sel = 2'b10;
      else if (rs != 5'd0 && rs == wr_w && rw_w) sel = 2'b01;
      return sel;
   endfunction

   always_comb begin
      state_d  = state_q;
      wcnt_d   = wcnt_q;
      memstall = 1'b0;
      case (state_q)
         RUN: begin
            if (memreqM && !memreadyM) begin
               memstall = 1'b1;
               state_d  = WAIT;
               wcnt_d   = 8'd1;
            end
         end
         WAIT: begin
            if (memreadyM) begin
               state_d = RUN;
               wcnt_d  = 8'd0;
            end else begin
               memstall = 1'b1;
               wcnt_d   = wcnt_q + 8'd1;
               if (wcnt_q == WCNT_LAST) state_d = ERR;
            end
         end
         ERR: begin
            memstall = 1'b1;
         end
         default: begin
            state_d = RUN;
            wcnt_d  = 8'd0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= RUN;
         wcnt_q  <= 8'd0;
      end else begin
         state_q <= state_d;
         wcnt_q  <= wcnt_d;
      end
   end

   assign memerr = (state_q == ERR);

   assign lwstall     = memtoregE && (rtE == rsD || rtE == rtD);
   assign branchstall = branchD &&
                        ((regwriteE && (writeregE == rsD || writeregE == rtD)) ||
                         (memtoregM && (writeregM == rsD || writeregM == rtD)));

   // A memory stall freezes the whole pipe and masks the D-stage hazards.
   always_comb begin
      stallF    = 1'b0;
      stallD    = 1'b0;
      stallE    = 1'b0;
      stallM    = 1'b0;
      flushE    = 1'b0;
      flushW    = 1'b0;
      forwardAD = 1'b0;
      forwardBD = 1'b0;
      forwardAE = 2'b00;
      forwardBE = 2'b00;
      if (!reset) begin
         forwardAE = fwd_sel(rsE, writeregM, regwriteM, writeregW, regwriteW);
         forwardBE = fwd_sel(rtE, writeregM, regwriteM, writeregW, regwriteW);
         forwardAD = (rsD != 5'd0) && (rsD == writeregM) && regwriteM;
         forwardBD = (rtD != 5'd0) && (rtD == writeregM) && regwriteM;
         if (memstall) begin
            stallF = 1'b1;
            stallD = 1'b1;
            stallE = 1'b1;
            stallM = 1'b1;
            flushW = 1'b1;
         end else begin
            stallF = lwstall | branchstall;
            stallD = lwstall | branchstall;
            flushE = lwstall | branchstall;
         end
      end
   end

`ifdef HAZARD_PERF_EN
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

   always_comb begin
      stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, stallF};
      flush_cnt_d = flush_cnt_q + {{(CNT_W-1){1'b0}}, (flushE | flushW)};
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign stall_cnt = stall_cnt_q;
   assign flush_cnt = flush_cnt_q;
`else
   assign stall_cnt = '0;
   assign flush_cnt = '0;
`endif

endmodule

// File: doc/hazard_unit.md
Name: hazard_unit

Overview:
Consumer end of the pipeline control bundle. It takes the per-stage regwrite/memtoreg/branch indications and register numbers, and returns stall, flush and forward controls. Its flushE output drives the E-stage clear on the control pipeline registers. It also owns a wait-state FSM for a variable-latency data memory, with a timeout and a sticky error flag.

Parameters:
MEM_TIMEOUT, 16, max consecutive M-stage wait cycles before memerr (legal range 2..255)
CNT_W, 32, width of the optional performance counters

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  synchronous, active-high
rsD, rtD  in  5  D-stage source regs
rsE, rtE  in  5  E-stage source regs
writeregE, writeregM, writeregW  in  5  destination reg per stage
regwriteE, regwriteM, regwriteW  in  1  write-enable per stage
memtoregE, memtoregM  in  1  load in E / M
branchD  in  1  branch in D
memreqM  in  1  M-stage load or store active
memreadyM  in  1  memory accepts/returns this cycle
stallF, stallD, stallE, stallM  out  1  hold stage register
flushE, flushW  out  1  insert bubble into E / W register
forwardAD, forwardBD  out  1  D-stage compare bypass from M
forwardAE, forwardBE  out  2  00 regfile, 01 from W, 10 from M
memerr  out  1  sticky memory timeout
stall_cnt, flush_cnt  out  CNT_W  performance counters (see Optional Feature)

Behaviour:
- Forwarding, combinational:
  - forwardAE = 10 if rsE!=0 && rsE==writeregM && regwriteM; else 01 if rsE!=0 && rsE==writeregW && regwriteW; else 00.
  - forwardBE: same rule using rtE.
  - M has priority over W.
- D-stage bypass: forwardAD = rsD!=0 && rsD==writeregM && regwriteM. forwardBD uses rtD.
- lwstall = memtoregE && (rtE==rsD || rtE==rtD).
- branchstall = branchD && ((regwriteE && writeregE∈{rsD,rtD}) || (memtoregM && writeregM∈{rsD,rtD})).
- FSM states RUN, WAIT, ERR; wait counter wcnt is 8 bits.
  - RUN: memstall = memreqM && !memreadyM. If memstall, go to WAIT and set wcnt=1.
  - WAIT: memstall=1 while !memreadyM.
    - memreadyM=1: memstall=0 in that same cycle; go to RUN, wcnt=0.
    - Otherwise wcnt increments. When wcnt==MEM_TIMEOUT-1 and still not ready, go to ERR.
  - ERR: memerr=1, memstall=1 permanently. Left only by reset.
- Output composition:
  - memstall=1: stallF=stallD=stallE=stallM=1, flushW=1, flushE=0. lwstall/branchstall are masked.
  - memstall=0: stallF=stallD=flushE=lwstall|branchstall; stallE=stallM=flushW=0.
- Simultaneous lwstall and branchstall produce a single stall/flush (OR), not a double.
- Reset (reset=1 sampled on an edge):
  - state=RUN, wcnt=0, memerr=0, counters=0.
  - While reset is high, all stall/flush outputs are forced 0 and forward outputs are forced 00. This includes reset asserted mid-WAIT or in ERR.
- Register $0 never forwards or stalls via the forwarding path. Zero-register filtering on lwstall is not applied; this is conservative and matches pipeline expectations.

Optional Feature:
- Macro HAZARD_PERF_EN.
- Defined:
  - stall_cnt increments every cycle stallF=1.
  - flush_cnt increments every cycle flushE=1 or flushW=1.
  - Both wrap modulo 2^CNT_W, are cleared by reset, and hold (do not count) while reset is high.
- Undefined: no counter flops; stall_cnt and flush_cnt are driven constant 0.
- All other behaviour is identical in both builds.

Test Plan:
- Forwarding: rsE=5, writeregM=5, regwriteM=1, writeregW=5, regwriteW=1 -> forwardAE=10. Set regwriteM=0 -> forwardAE=01. Set rsE=0 -> forwardAE=00.
- Load-use: memtoregE=1, rtE=8, rsD=8 -> stallF=stallD=flushE=1 for exactly that cycle, stallE=0. Next cycle with memtoregE=0 -> all 0.
- Branch hazard: branchD=1, rsD=3, regwriteE=1, writeregE=3 -> stall+flushE=1. Same cycle also memtoregE=1, rtE=3 -> still a single assertion. With writeregE=4 -> no stall.
- Memory wait: memreqM=1, memreadyM=0 for 3 cycles, then 1 -> stallF..M=1 and flushW=1 for 3 cycles, flushE=0 throughout, 0 on the ready cycle, FSM back in RUN.
- Timeout: MEM_TIMEOUT=4, memreqM=1, memreadyM held 0 -> memerr=1 from the cycle after the 4th wait cycle and stays 1 after memreadyM=1. Reset pulse -> memerr=0, stalls 0.
- HAZARD_PERF_EN: 5 lwstall cycles plus 3 mem-wait cycles -> stall_cnt=8, flush_cnt=8. Reset -> both 0. Without the macro -> both read 0.
